// File: rtl/fixed_to_seg7_formatter.sv
// Signed fixed-point to seven-segment formatter: sign digit plus integer and fraction
// digits, converted serially (double-dabble for the integer part, x10 for the fraction).
module fixed_to_seg7_formatter #(
   parameter int INT_BITS    = 16,
   parameter int FRAC_BITS   = 16,
   parameter int INT_DIGITS  = 4,
   parameter int FRAC_DIGITS = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [INT_BITS+FRAC_BITS-1:0]             value,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      ovf,
   output logic [6:0]                                seg_neg,
   output logic [7*(INT_DIGITS+FRAC_DIGITS)-1:0]     seg_digits
);

   localparam int unsigned W     = INT_BITS + FRAC_BITS;
   localparam int unsigned D     = INT_DIGITS + FRAC_DIGITS;
   localparam int unsigned BCD_W = 4 * INT_DIGITS;
   localparam int unsigned FD_W  = 4 * FRAC_DIGITS;
   localparam int unsigned PW    = FRAC_BITS + 4;
   localparam int unsigned CNT_W = $clog2(INT_BITS + FRAC_DIGITS + 1);
   localparam logic [63:0] MAX_INT = 64'(10 ** INT_DIGITS - 1);
   localparam logic [6:0]  SEG_MINUS = 7'b1111110;
   localparam logic [6:0]  SEG_BLANK = 7'b1111111;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ABS       = 3'd1,
      INT_CONV  = 3'd2,
      FRAC_CONV = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         val_q, val_d;
   logic                 neg_q, neg_d;
   logic                 ovf_int_q, ovf_int_d;
   logic [INT_BITS-1:0]  int_sh_q, int_sh_d;
   logic [FRAC_BITS-1:0] frac_q, frac_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [FD_W-1:0]      fdig_q, fdig_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 ovf_q, ovf_d;
   logic [6:0]           seg_neg_q, seg_neg_d;
   logic [7*D-1:0]       seg_digits_q, seg_digits_d;

   logic [W:0]           mag;
   logic [BCD_W-1:0]     bcd_adj;
   logic [PW-1:0]        prod;
   logic [4*D-1:0]       disp;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0001100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // Datapath helpers: W+1-bit magnitude keeps -2^(W-1) exact
   always_comb begin
      mag = val_q[W-1] ? ((W+1)'(0) - {val_q[W-1], val_q}) : {val_q[W-1], val_q};
      bcd_adj = bcd_q;
      for (int i = 0; i < INT_DIGITS; i++) begin
         if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
      prod = PW'(frac_q) * PW'(10);
      disp = ovf_int_q ? {D{4'd9}} : {bcd_q, fdig_q};
   end

   always_comb begin
      state_d      = state_q;
      val_d        = val_q;
      neg_d        = neg_q;
      ovf_int_d    = ovf_int_q;
      int_sh_d     = int_sh_q;
      frac_d       = frac_q;
      bcd_d        = bcd_q;
      fdig_d       = fdig_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      ovf_d        = ovf_q;
      seg_neg_d    = seg_neg_q;
      seg_digits_d = seg_digits_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               val_d   = value;
               state_d = ABS;
            end
         end
         ABS: begin
            neg_d     = val_q[W-1];
            ovf_int_d = 64'(mag[W:FRAC_BITS]) > MAX_INT;
            int_sh_d  = mag[W-1:FRAC_BITS];
            frac_d    = mag[FRAC_BITS-1:0];
            bcd_d     = '0;
            fdig_d    = '0;
            cnt_d     = '0;
            state_d   = INT_CONV;
         end
         INT_CONV: begin
            bcd_d    = {bcd_adj[BCD_W-2:0], int_sh_q[INT_BITS-1]};
            int_sh_d = int_sh_q << 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(INT_BITS - 1)) begin
               cnt_d   = '0;
               state_d = FRAC_CONV;
            end
         end
         FRAC_CONV: begin
            fdig_d = (fdig_q << 4) | FD_W'(prod[PW-1:FRAC_BITS]);
            frac_d = prod[FRAC_BITS-1:0];
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAC_DIGITS - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            done_d    = 1'b1;
            ovf_d     = ovf_int_q;
            seg_neg_d = (neg_q && (disp != '0)) ? SEG_MINUS : SEG_BLANK;
            for (int k = 0; k < D; k++) seg_digits_d[7*k +: 7] = seg7(disp[4*k +: 4]);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         val_q        <= '0;
         neg_q        <= 1'b0;
         ovf_int_q    <= 1'b0;
         int_sh_q     <= '0;
         frac_q       <= '0;
         bcd_q        <= '0;
         fdig_q       <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         seg_neg_q    <= SEG_BLANK;
         seg_digits_q <= {D{7'b0000001}};
      end else begin
         state_q      <= state_d;
         val_q        <= val_d;
         neg_q        <= neg_d;
         ovf_int_q    <= ovf_int_d;
         int_sh_q     <= int_sh_d;
         frac_q       <= frac_d;
         bcd_q        <= bcd_d;
         fdig_q       <= fdig_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
         seg_neg_q    <= seg_neg_d;
         seg_digits_q <= seg_digits_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign ovf        = ovf_q;
   assign seg_neg    = seg_neg_q;
   assign seg_digits = seg_digits_q;

endmodule
